// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control stage in front of a word-addressed RAM with no byte enables
module lsu_ctrl #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_fault,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);
  typedef enum logic [2:0] {IDLE, ACCESS, READ, WRITE, RESP} state_t;
  localparam logic [31:0] LIMIT = 32'(MEM_BYTES);
  state_t      state_q;
  logic        we_q, mis_q, flt_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, data_q;
  logic        mis_d, flt_d;
  logic [4:0]  sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext, merge;
  // Alignment/legality and range checks on the live request; misaligned wins over fault
  always_comb begin
    mis_d = ((req_funct3[1:0] == 2'b01) & req_addr[0])
          | ((req_funct3 == 3'b010) & (req_addr[1:0] != 2'b00))
          | (req_we ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                    : ((req_funct3[1:0] == 2'b11) | (req_funct3[2:1] == 2'b11)));
    flt_d = req_addr >= LIMIT;
  end
  // Lane selection: load extension from the captured word and sub-word store merge into it
  always_comb begin
    sh     = {addr_q[1:0], 3'b000};
    byte_v = 8'(data_q >> sh);
    half_v = addr_q[1] ? data_q[31:16] : data_q[15:0];
    ext    = (f3_q[1:0] == 2'b00) ? {{24{~f3_q[2] & byte_v[7]}}, byte_v}
           : (f3_q[1:0] == 2'b01) ? {{16{~f3_q[2] & half_v[15]}}, half_v}
           : data_q;
    merge  = (f3_q[1:0] == 2'b10) ? wdata_q
           : (f3_q[1:0] == 2'b01) ? (addr_q[1] ? {wdata_q[15:0], data_q[15:0]}
                                               : {data_q[31:16], wdata_q[15:0]})
           : (data_q & ~(32'hFF << sh)) | ({24'b0, wdata_q[7:0]} << sh);
  end
  // Outputs decode purely from registered state, so reset kills mem_we at once
  assign req_ready       = state_q == IDLE;
  assign resp_valid      = state_q == RESP;
  assign mem_we          = state_q == WRITE;
  assign mem_addr        = (state_q inside {ACCESS, READ, WRITE}) ? {addr_q[31:2], 2'b00} : '0;
  assign mem_din         = mem_we ? merge : '0;
  assign resp_misaligned = resp_valid & mis_q;
  assign resp_fault      = resp_valid & flt_q;
  assign resp_rdata      = (resp_valid & ~we_q & ~mis_q & ~flt_q) ? ext : '0;
  // Request capture and sequencing: one request in flight, errors skip the RAM entirely
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      flt_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          mis_q   <= mis_d;
          flt_q   <= ~mis_d & flt_d;
          state_q <= (mis_d | flt_d) ? RESP
                   : !req_we ? ACCESS
                   : (req_funct3 == 3'b010) ? WRITE : READ;
        end
        ACCESS: begin
          data_q  <= mem_dout;
          state_q <= RESP;
        end
        READ: begin
          data_q  <= mem_dout;
          state_q <= WRITE;
        end
        WRITE:   state_q <= RESP;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl against a byte-array memory model
module tb_lsu_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_we = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, resp_valid, resp_misaligned, resp_fault, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_din, mem_dout;

  typedef struct {
    logic [31:0] rd, wa, wd;
    logic        mis, flt;
    int          lat, nwe, acc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ram [0:255];
  logic [7:0]  mb  [0:1023];
  int          cyc = 0, checks = 0, failures = 0, wecnt = 0;

  lsu_ctrl #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
    .resp_fault(resp_fault), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_dout = ram[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[9:2]] <= mem_din;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endfunction

  // Reference model: byte-addressed memory, results derived from access size and signedness
  task automatic model(output exp_t e, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    int size;
    bit legal;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e.mis = !legal || (a % size != 0);
    e.flt = !e.mis && (a >= 1024);
    e.rd = 0; e.wa = 0; e.wd = 0; e.nwe = 0; e.acc = 0;
    if (e.mis || e.flt) e.lat = 1;
    else if (!we) begin
      e.lat = 2;
      for (int i = 0; i < size; i++) e.rd |= 32'(mb[a + i]) << (8 * i);
      if (!f3[2] && size < 4 && e.rd[8 * size - 1]) e.rd |= ~((32'd1 << (8 * size)) - 1);
    end else begin
      e.lat = (size == 4) ? 2 : 3;
      e.nwe = 1;
      for (int i = 0; i < size; i++) mb[a + i] = wd[8 * i +: 8];
      e.wa = a & ~32'd3;
      e.wd = {mb[e.wa + 3], mb[e.wa + 2], mb[e.wa + 1], mb[e.wa]};
    end
  endtask

  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input bit hold, output int acc);
    int t = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    acc = cyc;
    if (!req_ready) begin
      chk("ready_wait", 32'(req_ready), 32'd1);
      req_valid = 0;
      return;
    end
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    model(e, we, f3, a, wd);
    e.acc = cyc;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 0;
  endtask

  // Monitor: checks every RAM write and every response against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) wecnt = 0;
    else begin
      if (mem_we) begin
        wecnt++;
        if (q.size() == 0) chk("we_unexpected", 32'(mem_we), 32'd0);
        else begin
          chk("mem_addr", mem_addr, q[0].wa);
          chk("mem_din", mem_din, q[0].wd);
        end
      end
      if (resp_valid) begin
        if (q.size() == 0) chk("resp_unexpected", 32'(resp_valid), 32'd0);
        else begin
          e = q.pop_front();
          chk("rdata", resp_rdata, e.rd);
          chk("misaligned", 32'(resp_misaligned), 32'(e.mis));
          chk("fault", 32'(resp_fault), 32'(e.flt));
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("we_pulses", 32'(wecnt), 32'(e.nwe));
        end
        wecnt = 0;
      end
    end
  end

  initial begin
    int a0, acc[4], t;
    logic [31:0] w, snap;
    logic [7:0] sb[4];
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (i == 4) w = 32'h8899AABB;
      ram[i] = w;
      for (int k = 0; k < 4; k++) mb[4 * i + k] = w[8 * k +: 8];
    end
    #12;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1;
    // sub-word loads from word 0x10
    req(0, 3'b000, 32'h11, 0, 0, a0);
    req(0, 3'b100, 32'h11, 0, 0, a0);
    req(0, 3'b001, 32'h12, 0, 0, a0);
    req(0, 3'b101, 32'h12, 0, 0, a0);
    // read-modify-write stores
    req(1, 3'b000, 32'h11, 32'h55, 0, a0);
    req(1, 3'b001, 32'h12, 32'h1234, 0, a0);
    repeat (4) @(negedge clk);
    chk("rmw_word", ram[4], 32'h123455BB);
    req(1, 3'b010, 32'h20, 32'hDEADBEEF, 0, a0);
    req(0, 3'b010, 32'h20, 0, 0, a0);
    repeat (4) @(negedge clk);
    chk("sw_word", ram[8], 32'hDEADBEEF);
    // error cases
    req(0, 3'b010, 32'h22, 0, 0, a0);
    req(1, 3'b001, 32'h13, 1, 0, a0);
    req(0, 3'b011, 32'h10, 0, 0, a0);
    req(0, 3'b010, 32'h400, 0, 0, a0);
    req(0, 3'b010, 32'h402, 0, 0, a0);
    req(1, 3'b100, 32'h10, 1, 0, a0);
    // reset during the write cycle of a byte store
    snap = ram[12];
    for (int k = 0; k < 4; k++) sb[k] = mb[48 + k];
    req(1, 3'b000, 32'h31, 32'h77, 0, a0);
    t = 0;
    while (!mem_we && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("reach_write", 32'(mem_we), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_we", 32'(mem_we), 32'd0);
    chk("rst_mid_resp", 32'(resp_valid), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_addr", mem_addr, 32'd0);
    q.delete();
    for (int k = 0; k < 4; k++) mb[48 + k] = sb[k];
    repeat (2) @(negedge clk);
    chk("rst_ram_kept", ram[12], snap);
    rst_n = 1;
    req(0, 3'b010, 32'h30, 0, 0, a0);
    // back-to-back loads with valid held high
    for (int i = 0; i < 4; i++) req(0, 3'b010, 32'(4 * i), 0, 1, acc[i]);
    req_valid = 0;
    for (int i = 1; i < 4; i++) chk("b2b_spacing", 32'(acc[i] - acc[i - 1]), 32'd3);
    // randomized traffic
    repeat (300) begin
      logic [2:0] f3;
      logic [31:0] a;
      logic we;
      we = 1'($urandom % 2);
      f3 = ($urandom % 5 == 0) ? 3'($urandom % 8)
         : we ? 3'($urandom % 3) : 3'($urandom_range(0, 4) == 3 ? 5 : $urandom % 3);
      a = ($urandom % 10 == 0) ? $urandom_range(1020, 2100) : ($urandom % 1024);
      if ($urandom % 2 == 0) a = a & ~32'(3);
      req(we, f3, a, $urandom, bit'($urandom % 2), a0);
      if ($urandom % 4 == 0) begin
        req_valid = 0;
        repeat ($urandom % 3) @(negedge clk);
      end
    end
    req_valid = 0;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) chk("drain", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control stage directly upstream of the word-addressed data RAM. The RAM has asynchronous word read, synchronous word write, and no byte enables.
- Accepts one core memory request at a time over a valid/ready handshake.
- Performs alignment and range checks, builds sub-word stores by read-modify-write, and extracts and sign/zero-extends sub-word loads.
- Returns a single-cycle response pulse to the core's memory stage.

Parameters:
- MEM_BYTES, 1024, size of the data RAM in bytes; must be a power of two and at least 4.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  load result, extended to 32 bits
- resp_misaligned  out  1  alignment or illegal-funct3 error
- resp_fault  out  1  address out of range
- mem_we  out  1  RAM write enable
- mem_addr  out  32  RAM byte address, always word-aligned
- mem_din  out  32  RAM write data
- mem_dout  in  32  RAM read data (combinational from mem_addr)

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0:
  - state=IDLE, all captured registers cleared.
  - req_ready=1; resp_valid, resp_misaligned, resp_fault, mem_we = 0.
  - mem_addr, mem_din, resp_rdata = 0.
- Reset asserted mid-operation forces IDLE immediately. mem_we drops combinationally with the state, so no partial write occurs, and no response is issued.
- States: IDLE, ACCESS, READ, WRITE, RESP.
- Handshake:
  - req_ready=1 only in IDLE.
  - A request is accepted on a rising edge with req_valid & req_ready. req_we, funct3, addr and wdata are latched at acceptance.
  - Request inputs are ignored in every other state.
- Checks at accept (priority: misaligned, then fault):
  - Misaligned when any of:
    - H/HU with addr[0]=1
    - W with addr[1:0]!=0
    - load funct3 in {011, 110, 111}
    - store funct3 not in {000, 001, 010}
  - Fault when addr >= MEM_BYTES.
  - On either error: next state is RESP with the matching flag set, resp_rdata=0, no RAM access.
- Transitions from IDLE on accept:
  - Load → ACCESS.
  - SW → WRITE.
  - SB/SH → READ.
- ACCESS: mem_addr = {addr[31:2], 2'b00}. mem_dout is captured at the end of the cycle → RESP.
- READ: same mem_addr. The old word is captured → WRITE.
- WRITE:
  - mem_we=1 for exactly this cycle; mem_addr is the aligned word address.
  - mem_din by width:
    - SW: wdata.
    - SH: old word with halfword addr[1] replaced by wdata[15:0].
    - SB: old word with byte addr[1:0] replaced by wdata[7:0].
  - → RESP.
- RESP:
  - resp_valid=1 for one cycle → IDLE.
  - Error flags are valid only while resp_valid=1.
- Load extraction from the captured word:
  - B/BU use byte addr[1:0]; H/HU use halfword addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes the word through.
  - For stores, resp_rdata=0.
- Outside ACCESS/READ/WRITE: mem_addr=0, mem_din=0, mem_we=0.
- Latency, counting the accept edge as cycle 0, to the cycle in which resp_valid is high:
  - Loads and SW: 2.
  - SB/SH: 3.
  - Errors: 1.
- Throughput: the next request can be accepted in the cycle after RESP, i.e. while back in IDLE.
- Only the single accepted request is ever in flight.

Test Plan:
1. RAM word 0x10 = 0x8899AABB. LB at 0x11 → resp_rdata=0xFFFFFFAA, 2 cycles after accept. LBU at 0x11 → 0x000000AA. LH at 0x12 → 0xFFFF8899. LHU at 0x12 → 0x00008899.
2. Same word. SB 0x11 with wdata 0x00000055 → one mem_we pulse with mem_din=0x8899 55BB (i.e. 0x889955BB), response at cycle 3. Then SH 0x12 with wdata 0x1234 → word becomes 0x123455BB.
3. SW 0x20 with wdata 0xDEADBEEF → mem_we high for exactly 1 cycle with mem_addr=0x20; response at cycle 2; readback LW 0x20 = 0xDEADBEEF.
4. LW 0x22, SH 0x13, load funct3=011 → each gives resp_misaligned=1, resp_fault=0, no mem_we, response at cycle 1. LW 0x400 with MEM_BYTES=1024 → resp_fault=1, no RAM access. Misaligned and out of range together → only resp_misaligned=1.
5. Drop rst_n while in WRITE of an SB to 0x30 → mem_we falls immediately, RAM word unchanged, no resp_valid; after release, req_ready=1 and a new LW completes normally.
6. req_valid held high for 4 back-to-back LWs → accepts only in IDLE, exactly 4 resp_valid pulses each 3 cycles apart, no duplicated acceptance.
